// File: rtl/stream_demux_pkg.sv
// Shared defaults and helpers for the stream demultiplexer and its per-port slots.
package stream_demux_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_N_OUT = 4;

    // Width of a port index; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output buffer: a full flag plus a data register, loaded from upstream and popped downstream.
module stream_demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             pop,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    // A load wins over a pop so a word can be replaced in the same cycle it leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Routes an upstream valid/ready stream to one of N_OUT single-entry output ports chosen by up_sel.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N_OUT = DEFAULT_N_OUT,
    localparam int SW   = sel_width(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   up_valid,
    output logic                   up_ready,
    input  logic [WIDTH-1:0]       up_data,
    input  logic [SW-1:0]          up_sel,
    output logic [N_OUT-1:0]       down_valid,
    input  logic [N_OUT-1:0]       down_ready,
    output logic [N_OUT*WIDTH-1:0] down_data,
    output logic                   sel_err
);

    logic [N_OUT-1:0] full;
    logic [N_OUT-1:0] load;
    logic [N_OUT-1:0] pop;
    logic             sel_ok;

    // Out-of-range selects are always ready so a bad word is swallowed instead of stalling upstream.
    always_comb begin
        sel_ok   = 1'b0;
        up_ready = 1'b1;
        load     = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (up_sel == SW'(i)) begin
                sel_ok   = 1'b1;
                up_ready = !full[i] || down_ready[i];
            end
        end
        for (int i = 0; i < N_OUT; i++) begin
            load[i] = up_valid && up_ready && (up_sel == SW'(i));
        end
    end

    assign pop        = full & down_ready;
    assign down_valid = full;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= up_valid && !sel_ok;
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        stream_demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk  (clk),
            .rst  (rst),
            .load (load[g]),
            .pop  (pop[g]),
            .d    (up_data),
            .valid(full[g]),
            .q    (down_data[g*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_stream_demux.sv
// Directed-vector and scoreboard bench for stream_demux (4-port instance plus a 3-port instance).
module tb_stream_demux;

    logic clk;
    logic rst;

    logic        up_valid;
    logic        up_ready;
    logic [7:0]  up_data;
    logic [1:0]  up_sel;
    logic [3:0]  down_valid;
    logic [3:0]  down_ready;
    logic [31:0] down_data;
    logic        sel_err;

    logic        up_valid3;
    logic        up_ready3;
    logic [7:0]  up_data3;
    logic [1:0]  up_sel3;
    logic [2:0]  down_valid3;
    logic [2:0]  down_ready3;
    logic [23:0] down_data3;
    logic        sel_err3;

    int n_compared;
    int n_mismatched;

    stream_demux #(.WIDTH(8), .N_OUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .up_data   (up_data),
        .up_sel    (up_sel),
        .down_valid(down_valid),
        .down_ready(down_ready),
        .down_data (down_data),
        .sel_err   (sel_err)
    );

    stream_demux #(.WIDTH(8), .N_OUT(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .up_valid  (up_valid3),
        .up_ready  (up_ready3),
        .up_data   (up_data3),
        .up_sel    (up_sel3),
        .down_valid(down_valid3),
        .down_ready(down_ready3),
        .down_data (down_data3),
        .sel_err   (sel_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [7:0]  data;
        logic [3:0]  dr;
        logic        exp_ready;
        logic [3:0]  exp_dv;
        logic [31:0] exp_dd;
    } vec_t;

    vec_t vecs[12];

    // Drive at the falling edge and settle, so checks land between active edges.
    task automatic applyStimulus(input logic v, input logic [1:0] sel, input logic [7:0] data,
                                 input logic [3:0] dr);
        @(negedge clk);
        up_valid   = v;
        up_sel     = sel;
        up_data    = data;
        down_ready = dr;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    logic [3:0] exp_full;
    logic [7:0] exp_data[4];
    logic [3:0] hold_prev;
    logic [7:0] prev_data[4];
    int         n_accepts;
    int         rand_fails;

    initial begin
        n_compared   = 0;
        n_mismatched = 0;

        vecs[0]  = '{1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0000, 32'h0000_0000};
        vecs[1]  = '{1'b0, 2'd2, 8'h00, 4'b0000, 1'b0, 4'b0100, 32'h00A5_0000};
        vecs[2]  = '{1'b1, 2'd2, 8'h3C, 4'b0000, 1'b0, 4'b0100, 32'h00A5_0000};
        vecs[3]  = '{1'b1, 2'd0, 8'h11, 4'b0000, 1'b1, 4'b0100, 32'h00A5_0000};
        vecs[4]  = '{1'b1, 2'd2, 8'h3C, 4'b0100, 1'b1, 4'b0101, 32'h00A5_0011};
        vecs[5]  = '{1'b0, 2'd0, 8'h00, 4'b0001, 1'b1, 4'b0101, 32'h003C_0011};
        vecs[6]  = '{1'b1, 2'd3, 8'h99, 4'b0000, 1'b1, 4'b0100, 32'h003C_0011};
        vecs[7]  = '{1'b1, 2'd1, 8'h42, 4'b1100, 1'b1, 4'b1100, 32'h993C_0011};
        vecs[8]  = '{1'b0, 2'd1, 8'hFF, 4'b0000, 1'b0, 4'b0010, 32'h993C_4211};
        vecs[9]  = '{1'b1, 2'd1, 8'hFF, 4'b0000, 1'b0, 4'b0010, 32'h993C_4211};
        vecs[10] = '{1'b1, 2'd0, 8'h5A, 4'b0010, 1'b1, 4'b0010, 32'h993C_4211};
        vecs[11] = '{1'b0, 2'd1, 8'h00, 4'b0000, 1'b1, 4'b0001, 32'h993C_425A};

        rst         = 1'b1;
        up_valid    = 1'b0;
        up_sel      = '0;
        up_data     = '0;
        down_ready  = '0;
        up_valid3   = 1'b0;
        up_sel3     = '0;
        up_data3    = '0;
        down_ready3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_down_valid", {28'd0, down_valid}, 32'd0);
        checkOutput("reset_down_data", down_data, 32'd0);
        checkOutput("reset_sel_err", {31'd0, sel_err}, 32'd0);
        checkOutput("reset_down_valid3", {29'd0, down_valid3}, 32'd0);

        // Table: each row's expectations are the outputs visible before that row's edge.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].v, vecs[i].sel, vecs[i].data, vecs[i].dr);
            checkOutput($sformatf("vec%0d_up_ready", i), {31'd0, up_ready}, {31'd0, vecs[i].exp_ready});
            checkOutput($sformatf("vec%0d_down_valid", i), {28'd0, down_valid}, {28'd0, vecs[i].exp_dv});
            checkOutput($sformatf("vec%0d_down_data", i), down_data, vecs[i].exp_dd);
        end

        // Mid-operation reset with ports 0 and 2 full drops both words.
        applyStimulus(1'b1, 2'd2, 8'h77, 4'b0000);
        checkOutput("pre_rst_up_ready", {31'd0, up_ready}, 32'd1);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
        checkOutput("pre_rst_down_valid", {28'd0, down_valid}, 32'h5);
        rst = 1'b1;
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
        rst = 1'b0;
        checkOutput("post_rst_down_valid", {28'd0, down_valid}, 32'd0);
        checkOutput("post_rst_down_data", down_data, 32'd0);
        applyStimulus(1'b1, 2'd0, 8'h12, 4'b0000);
        checkOutput("post_rst_up_ready", {31'd0, up_ready}, 32'd1);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
        checkOutput("post_rst_accept_valid", {28'd0, down_valid}, 32'h1);
        checkOutput("post_rst_accept_data", down_data, 32'h0000_0012);

        // Back-to-back stream to port 1 with the consumer always ready.
        n_accepts = 0;
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) applyStimulus(1'b1, 2'd1, 8'(k + 1), 4'b0010);
            else        applyStimulus(1'b0, 2'd1, 8'h00, 4'b0010);
            if (k < 16) begin
                checkOutput($sformatf("stream%0d_up_ready", k), {31'd0, up_ready}, 32'd1);
                if (up_ready) n_accepts++;
            end
            if (k > 0) begin
                checkOutput($sformatf("stream%0d_valid1", k), {31'd0, down_valid[1]}, 32'd1);
                checkOutput($sformatf("stream%0d_data1", k), {24'd0, down_data[15:8]}, 32'(k));
            end
        end
        applyStimulus(1'b0, 2'd1, 8'h00, 4'b0000);
        checkOutput("stream_accepts", 32'(n_accepts), 32'd16);
        checkOutput("stream_drained", {31'd0, down_valid[1]}, 32'd0);

        // Port 0 stays stalled while port 3 keeps flowing.
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b1, 2'd3, 8'(8'hC0 + j), 4'b1000);
            checkOutput($sformatf("iso%0d_up_ready3", j), {31'd0, up_ready}, 32'd1);
            checkOutput($sformatf("iso%0d_port0_data", j), {24'd0, down_data[7:0]}, 32'h12);
            checkOutput($sformatf("iso%0d_port0_valid", j), {31'd0, down_valid[0]}, 32'd1);
            if (j > 0) begin
                checkOutput($sformatf("iso%0d_port3_data", j), {24'd0, down_data[31:24]}, 32'(8'hC0 + j - 1));
            end
            up_sel = 2'd0;
            #1;
            checkOutput($sformatf("iso%0d_up_ready0", j), {31'd0, up_ready}, 32'd0);
            up_sel = 2'd3;
            #1;
        end
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
        checkOutput("iso_stalled_ready0", {31'd0, up_ready}, 32'd0);
        checkOutput("iso_port3_last", {24'd0, down_data[31:24]}, 32'hC3);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b0001);
        checkOutput("iso_released_ready0", {31'd0, up_ready}, 32'd1);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
        checkOutput("iso_port0_popped", {31'd0, down_valid[0]}, 32'd0);

        // Out-of-range select on the 3-port instance.
        @(negedge clk);
        up_valid3 = 1'b1;
        up_sel3   = 2'd3;
        up_data3  = 8'h77;
        #1;
        checkOutput("bad_sel_up_ready", {31'd0, up_ready3}, 32'd1);
        checkOutput("bad_sel_err_before", {31'd0, sel_err3}, 32'd0);
        @(negedge clk);
        up_valid3 = 1'b0;
        #1;
        checkOutput("bad_sel_err_pulse", {31'd0, sel_err3}, 32'd1);
        checkOutput("bad_sel_down_valid", {29'd0, down_valid3}, 32'd0);
        @(negedge clk);
        up_valid3 = 1'b1;
        up_sel3   = 2'd2;
        up_data3  = 8'h55;
        #1;
        checkOutput("bad_sel_err_cleared", {31'd0, sel_err3}, 32'd0);
        @(negedge clk);
        up_valid3 = 1'b0;
        #1;
        checkOutput("sel3_good_valid", {29'd0, down_valid3}, 32'h4);
        checkOutput("sel3_good_data", {8'd0, down_data3}, 32'h0055_0000);

        // Random traffic against a one-entry-per-port reference model.
        rst = 1'b1;
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
        rst        = 1'b0;
        exp_full   = '0;
        hold_prev  = '0;
        rand_fails = 0;
        for (int p = 0; p < 4; p++) begin
            exp_data[p]  = '0;
            prev_data[p] = '0;
        end
        for (int c = 0; c < 10000 && rand_fails < 5; c++) begin
            logic        v;
            logic [1:0]  s;
            logic [7:0]  d;
            logic [3:0]  dr;
            logic        exp_ready;
            logic        ok;
            v  = 1'($urandom_range(0, 1));
            s  = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            dr = 4'($urandom);
            applyStimulus(v, s, d, dr);
            exp_ready = !exp_full[s] || dr[s];
            ok = (up_ready === exp_ready) && (down_valid === exp_full) && (sel_err === 1'b0);
            for (int p = 0; p < 4; p++) begin
                if (exp_full[p] && down_data[p*8 +: 8] !== exp_data[p]) ok = 1'b0;
                if (hold_prev[p] && down_data[p*8 +: 8] !== prev_data[p]) ok = 1'b0;
            end
            n_compared++;
            if (!ok) begin
                n_mismatched++;
                rand_fails++;
                $display("[TB] FAIL rand_cycle%0d: got ready=%b valid=%b data=%h err=%b, expected ready=%b valid=%b",
                         c, up_ready, down_valid, down_data, sel_err, exp_ready, exp_full);
            end
            for (int p = 0; p < 4; p++) begin
                hold_prev[p] = exp_full[p] && !dr[p];
                prev_data[p] = down_data[p*8 +: 8];
                if (exp_full[p] && dr[p]) exp_full[p] = 1'b0;
            end
            if (v && exp_ready) begin
                exp_full[s] = 1'b1;
                exp_data[s] = d;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width in bits of every stream.
REQ-002 The block SHALL have parameter N_OUT, default 4, range 2..8, meaning the number of downstream ports; SW = $clog2(N_OUT).
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, meaning the synchronous active-high reset.
REQ-005 The block SHALL have port up_valid, input, 1 bit, meaning the upstream word is valid.
REQ-006 The block SHALL have port up_ready, output, 1 bit, meaning the block accepts the upstream word this cycle.
REQ-007 The block SHALL have port up_data, input, WIDTH bits, meaning the upstream payload.
REQ-008 The block SHALL have port up_sel, input, SW bits, meaning the destination port index.
REQ-009 The block SHALL have port down_valid, output, N_OUT bits, meaning bit i is set when port i holds a word.
REQ-010 The block SHALL have port down_ready, input, N_OUT bits, meaning bit i is set when the port i consumer takes its word.
REQ-011 The block SHALL have port down_data, output, N_OUT*WIDTH bits, meaning port i payload at bits [i*WIDTH +: WIDTH].
REQ-012 The block SHALL have port sel_err, output, 1 bit, meaning a one-cycle pulse when a word with up_sel >= N_OUT was discarded.

Function
REQ-013 Each port SHALL own a one-entry buffer made of a full flag and a WIDTH-bit data register; down_valid[i] SHALL equal full[i].
REQ-014 up_ready SHALL be 1 when up_sel >= N_OUT; otherwise it SHALL equal !full[up_sel] | down_ready[up_sel], a combinational function of up_sel, state and down_ready.
REQ-015 An accept SHALL occur on a cycle with up_valid & up_ready; up_sel and up_data SHALL be ignored when up_valid is 0.
REQ-016 An accept with valid sel = k SHALL load data[k] and set full[k] at the next edge, giving 1-cycle latency; down_valid[k] SHALL rise on the following cycle.
REQ-017 A pop on port i SHALL occur on a cycle with down_valid[i] & down_ready[i] and SHALL clear full[i] at the next edge.
REQ-018 A simultaneous pop and accept on the same port SHALL keep full at 1 and load the new data; this sustains 1 word/cycle with no bubble.
REQ-019 Pops on other ports SHALL proceed independently in the same cycle as an accept.
REQ-020 down_data[i] SHALL hold stable while down_valid[i] & !down_ready[i].
REQ-021 Word order SHALL be preserved per port; no word SHALL be duplicated or lost except on an invalid sel.
REQ-022 An accept with up_sel >= N_OUT (reachable only for non-power-of-2 N_OUT) SHALL discard the word, leave all buffers unchanged, and set sel_err to 1 for exactly the next cycle.
REQ-023 When the port is full and down_ready[k] is 0, up_ready SHALL be 0 and the upstream SHALL hold its word, with no state change.
REQ-024 down_valid SHALL be independent of down_ready, with no combinational path in that direction.

Reset
REQ-025 While rst is sampled high, all full flags, all data registers and sel_err SHALL be 0 at the next edge, so down_valid is 0 and down_data is 0.
REQ-026 Reset asserted mid-operation SHALL drop buffered words without emitting them; up_ready SHALL still follow REQ-014 using the cleared state.

Structure
REQ-027 Package stream_demux_pkg SHALL hold the default WIDTH and N_OUT constants and the sel-width helper; the block SHALL import it.
REQ-028 The per-port buffer SHALL be sub-module stream_demux_slot (ports clk, rst, load, pop, d, valid, q), instantiated N_OUT times by generate.
REQ-029 The top SHALL contain only sel decode, up_ready mux, sel_err register and slot instances.

Verification
REQ-030 Reset, then with all down_ready=0 send 0xA5 to sel 2: down_valid=4'b0100 and down_data[2]=0xA5 one cycle after the accept; up_ready to sel 2 then 0.
REQ-031 Hold down_ready[1]=1 and stream 0x01..0x10 to sel 1 on consecutive cycles: 16 accepts in 16 cycles, port 1 emits 0x01..0x10 in order, no bubbles.
REQ-032 Port 0 full with down_ready[0]=0 while words go to sel 3: port 3 accepts and emits them, port 0 data stays constant, and up_ready for sel 0 stays 0 until down_ready[0]=1.
REQ-033 With N_OUT=3, send up_sel=3 with data 0x77: up_ready=1, sel_err=1 for one cycle, and down_valid stays 0.
REQ-034 With ports 0 and 2 full, assert rst for one cycle: down_valid=0 and down_data=0 after the edge; a subsequent word to sel 0 is accepted normally.
REQ-035 Random up_valid/up_sel/down_ready for 10k cycles: the scoreboard shows per-port order preserved, no loss or duplication, and REQ-020 holds every cycle.
